// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types and defaults.
// Holds the receive FSM state encoding and a 2-of-3 majority helper.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        BITS      = 2'd2,
        WAIT_HIGH = 2'd3
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one tick every max(div,1) clks.
// A synchronous clear restarts the period so a frame's ticks align to its start.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_max;

    // A divisor of 0 behaves as 1; >= keeps ticking if the divisor shrank.
    assign w_max  = (i_div == '0) ? '0 : i_div - DIV_W'(1);
    assign o_tick = (r_cnt >= w_max);

    // Count to the terminal value, wrap on tick, restart on clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: UART receive front-end - synchroniser, start qualification
// and one mid-bit sample per frame bit. Option: RX_MAJORITY_VOTE_EN (2-of-3 vote).
module rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DIV_W      = 16,
    parameter int FRAME_BITS = UART_FRAME_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    output logic             strt_bit,
    output logic             bit_valid,
    output logic             bit_data,
    output logic             false_start,
    output logic             framing_err,
    output logic             busy
);

`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif
    localparam int TCW = $clog2(OVERSAMPLE + 1);
    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam logic [TCW-1:0] START_TICK = TCW'(OVERSAMPLE / 2 + VOTE_LAG);
    localparam logic [TCW-1:0] BIT_TICK   = TCW'(OVERSAMPLE);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_BITS - 1);

    logic [1:0]     r_sync;
    logic [1:0]     r_primed;
    logic           r_armed;
    rx_state_t      r_state;
    rx_state_t      w_state_nxt;
    logic [TCW-1:0] r_tick_cnt;
    logic [TCW-1:0] w_tick_cnt_nxt;
    logic [TCW-1:0] w_tick_num;
    logic [BCW-1:0] r_bit_cnt;
    logic [BCW-1:0] w_bit_cnt_nxt;
    logic           w_rx_s;
    logic           w_os_tick;
    logic           w_clr;
    logic           w_sample;
    logic           r_strt_bit;
    logic           r_bit_valid;
    logic           r_bit_data;
    logic           r_false_start;
    logic           r_framing_err;
    logic           r_busy;
    logic           w_strt_nxt;
    logic           w_valid_nxt;
    logic           w_data_nxt;
    logic           w_false_nxt;
    logic           w_ferr_nxt;

    assign w_rx_s     = r_sync[1];
    assign w_tick_num = r_tick_cnt + TCW'(1);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_clr  (w_clr),
        .i_div  (baud_div),
        .o_tick (w_os_tick)
    );

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] r_vote;

    // Keep the two previous tick samples for the 2-of-3 vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vote <= 2'b11;
        end else if (w_os_tick) begin
            r_vote <= {r_vote[0], w_rx_s};
        end
    end

    assign w_sample = maj3(r_vote[1], r_vote[0], w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    // Two-flop synchroniser; r_primed marks when it reflects the real line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_primed <= 2'b00;
        end else begin
            r_sync   <= {r_sync[0], rx};
            r_primed <= {r_primed[0], 1'b1};
        end
    end

    // Arm start detection only once the line has really been seen high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (r_primed[1] && w_rx_s) begin
            r_armed <= 1'b1;
        end
    end

    // Next state, counters and the pulse values to register.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_clr          = 1'b0;
        w_strt_nxt     = 1'b0;
        w_valid_nxt    = 1'b0;
        w_data_nxt     = r_bit_data;
        w_false_nxt    = 1'b0;
        w_ferr_nxt     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_nxt    = START;
                    w_tick_cnt_nxt = '0;
                    w_clr          = 1'b1;
                end
            end
            START: begin
                if (w_os_tick) begin
                    w_tick_cnt_nxt = w_tick_num;
                    if (w_tick_num == START_TICK) begin
                        if (!w_sample) begin
                            w_strt_nxt     = 1'b1;
                            w_tick_cnt_nxt = '0;
                            w_bit_cnt_nxt  = '0;
                            w_state_nxt    = BITS;
                        end else begin
                            w_false_nxt = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            BITS: begin
                if (w_os_tick) begin
                    w_tick_cnt_nxt = w_tick_num;
                    if (w_tick_num == BIT_TICK) begin
                        w_tick_cnt_nxt = '0;
                        w_valid_nxt    = 1'b1;
                        w_data_nxt     = w_sample;
                        w_bit_cnt_nxt  = r_bit_cnt + BCW'(1);
                        if (r_bit_cnt == LAST_BIT) begin
                            if (w_sample) begin
                                w_state_nxt = IDLE;
                            end else begin
                                w_ferr_nxt  = 1'b1;
                                w_state_nxt = WAIT_HIGH;
                            end
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_strt_bit    <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_bit_data    <= 1'b0;
            r_false_start <= 1'b0;
            r_framing_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_strt_bit    <= w_strt_nxt;
            r_bit_valid   <= w_valid_nxt;
            r_bit_data    <= w_data_nxt;
            r_false_start <= w_false_nxt;
            r_framing_err <= w_ferr_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign strt_bit    = r_strt_bit;
    assign bit_valid   = r_bit_valid;
    assign bit_data    = r_bit_data;
    assign false_start = r_false_start;
    assign framing_err = r_framing_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// tb_rx_bit_sampler: line waveform is planned up front, a frame-level model
// predicts pulse events, and a negedge monitor pops and compares them.
module tb_rx_bit_sampler;

    localparam int OS   = 16;
    localparam int FB   = 10;
    localparam int DW   = 16;
    localparam int MAXW = 40000;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int S = OS / 2 + 1;
`else
    localparam int S = OS / 2;
`endif

    typedef struct {
        int ecyc;
        int kind;
        bit data;
        bit ferr;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [DW-1:0] baud_div = DW'(1);
    logic          strt_bit;
    logic          bit_valid;
    logic          bit_data;
    logic          false_start;
    logic          framing_err;
    logic          busy;

    rx_bit_sampler #(
        .OVERSAMPLE (OS),
        .DIV_W      (DW),
        .FRAME_BITS (FB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .baud_div    (baud_div),
        .strt_bit    (strt_bit),
        .bit_valid   (bit_valid),
        .bit_data    (bit_data),
        .false_start (false_start),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit  wave[MAXW];
    int  divw[MAXW];
    bit  exp_busy[MAXW];
    ev_t expq[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  wp = 1;
    int  cur_div = 1;

    function automatic void put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (wp < MAXW) begin
                wave[wp] = v;
                divw[wp] = cur_div;
                wp++;
            end
        end
    endfunction

    function automatic int add_frame(input logic [7:0] d, input bit par,
                                     input bit stp, input int div);
        int bl;
        int fall;
        cur_div = div;
        bl = OS * ((div == 0) ? 1 : div);
        fall = wp;
        put(1'b0, bl);
        for (int i = 0; i < 8; i++) put(d[i], bl);
        put(par, bl);
        put(stp, bl);
        return fall;
    endfunction

    // rx_s seen at edge e is the line value captured two edges earlier.
    function automatic bit rxs(input int e);
        if (e - 2 < 1 || e - 2 >= MAXW) return 1'b1;
        return wave[e-2];
    endfunction

    function automatic bit smp(input int e, input int p);
`ifdef RX_MAJORITY_VOTE_EN
        int a;
        a = int'(rxs(e)) + int'(rxs(e - p)) + int'(rxs(e - 2 * p));
        return (a >= 2);
`else
        return rxs(e);
`endif
    endfunction

    function automatic void push_ev(input int c, input int k, input bit d, input bit fe);
        ev_t ev;
        ev.ecyc = c;
        ev.kind = k;
        ev.data = d;
        ev.ferr = fe;
        expq.push_back(ev);
    endfunction

    function automatic void set_busy(input int a, input int b);
        for (int c = a; c <= b && c < MAXW; c++) exp_busy[c] = 1'b1;
    endfunction

    // Frame-level prediction for a reset segment whose first edge is f.
    function automatic void run_model(input int f, input int last);
        int e;
        int t;
        int p;
        int de;
        int ej;
        bit v;
        bit armed;
        for (int c = f; c < MAXW; c++) exp_busy[c] = 1'b0;
        e = f + 2;
        armed = 1'b0;
        v = 1'b1;
        ej = 0;
        while (e <= last) begin
            if (armed && !rxs(e)) begin
                t = e;
                p = (divw[t] == 0) ? 1 : divw[t];
                de = t + S * p;
                if (smp(de, p)) begin
                    push_ev(de, 2, 1'b0, 1'b0);
                    set_busy(t, de - 1);
                    e = de + 1;
                end else begin
                    push_ev(de, 0, 1'b0, 1'b0);
                    for (int j = 1; j <= FB; j++) begin
                        ej = de + j * OS * p;
                        v = smp(ej, p);
                        push_ev(ej, 1, v, (j == FB) && !v);
                    end
                    if (v) begin
                        set_busy(t, ej - 1);
                        e = ej + 1;
                    end else begin
                        e = ej + 1;
                        while (e <= last && !rxs(e)) e++;
                        set_busy(t, e - 1);
                        e = e + 1;
                    end
                end
            end else begin
                if (rxs(e)) armed = 1'b1;
                e++;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        rx = wave[cyc+1];
        baud_div = DW'(divw[cyc+1]);
    endtask

    task automatic chk(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b at edge %0d", name, got, want, cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_strt_bit"}, strt_bit, 1'b0);
        chk({tag, "_bit_valid"}, bit_valid, 1'b0);
        chk({tag, "_bit_data"}, bit_data, 1'b0);
        chk({tag, "_false_start"}, false_start, 1'b0);
        chk({tag, "_framing_err"}, framing_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Monitor: busy every cycle, and each pulse against the queue head.
    always @(negedge clk) begin
        int  k;
        ev_t ev;
        n_cmp++;
        if (busy !== exp_busy[cyc]) begin
            n_err++;
            $display("FAIL busy: got %b want %b at edge %0d", busy, exp_busy[cyc], cyc);
        end
        if (strt_bit || bit_valid || false_start || framing_err) begin
            k = 3;
            if (strt_bit && !bit_valid && !false_start && !framing_err) k = 0;
            else if (bit_valid && !strt_bit && !false_start) k = 1;
            else if (false_start && !strt_bit && !bit_valid && !framing_err) k = 2;
            n_cmp++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got kind %0d data %b ferr %b at edge %0d, want none",
                         k, bit_data, framing_err, cyc);
            end else begin
                ev = expq.pop_front();
                if (ev.ecyc != cyc || ev.kind != k ||
                    (k == 1 && (ev.data != bit_data || ev.ferr != framing_err))) begin
                    n_err++;
                    $display("FAIL event: got kind %0d data %b ferr %b at edge %0d, want kind %0d data %b ferr %b at edge %0d",
                             k, bit_data, framing_err, cyc, ev.kind, ev.data, ev.ferr, ev.ecyc);
                end
            end
        end
    end

    initial begin
        int   q;
        int   f;
        int   last;
        int   fall;
        int   dv;
        bit   stp;
        ev_t  keep[$];
        logic [7:0] d;

        for (int i = 0; i < MAXW; i++) begin
            wave[i] = 1'b1;
            divw[i] = 1;
            exp_busy[i] = 1'b0;
        end

        // Line low out of reset, then high: must never start a frame.
        put(1'b0, 60);
        put(1'b1, 30);
        // 0x55, even parity 0, stop 1, baud_div 1.
        fall = add_frame(8'h55, 1'b0, 1'b1, 1);
        put(1'b1, 30);
        // Four-clock glitch: false start.
        put(1'b0, 4);
        put(1'b1, 60);
        // Stop bit 0 with the line held low afterwards.
        fall = add_frame(8'h3C, 1'b0, 1'b0, 1);
        put(1'b0, 50);
        put(1'b1, 40);
        // Divisor 0 and divisor 3.
        fall = add_frame(8'h96, 1'b0, 1'b1, 0);
        put(1'b1, 30);
        fall = add_frame(8'h5A, 1'b0, 1'b1, 3);
        put(1'b1, 40);
        // One-tick low glitch at the centre of data bit 2 (a 1).
        fall = add_frame(8'hFF, 1'b0, 1'b1, 2);
        wave[fall + (OS / 2 + 3 * OS) * 2] = 1'b0;
        wave[fall + (OS / 2 + 3 * OS) * 2 + 1] = 1'b0;
        put(1'b1, 40);
        // Randomized frames, error stops and idle glitches.
        for (int n = 0; n < 12; n++) begin
            dv = $urandom_range(0, 3);
            d = 8'($urandom);
            stp = ($urandom_range(0, 5) != 0);
            fall = add_frame(d, 1'($urandom), stp, dv);
            if (!stp) put(1'b0, $urandom_range(10, 40));
            put(1'b1, $urandom_range(5, 40));
            if ($urandom_range(0, 3) == 0) begin
                put(1'b0, $urandom_range(1, 3));
                put(1'b1, 60);
            end
        end
        // Frame cut by reset in data bit 3, then a clean frame.
        fall = add_frame(8'h07, 1'b1, 1'b1, 1);
        q = fall + 2 + 4 * OS;
        put(1'b1, 40);
        fall = add_frame(8'hA3, 1'b0, 1'b1, 1);
        put(1'b1, 40);
        last = wp - 1;

        rx = wave[1];
        baud_div = DW'(divw[1]);
        #1;
        chk_outputs_zero("reset_state");
        repeat (3) step();
        reset = 1'b0;
        f = cyc + 1;
        run_model(f, last);

        while (cyc < q) step();
        reset = 1'b1;
        #1;
        chk_outputs_zero("midframe_reset");
        keep = {};
        foreach (expq[i]) if (expq[i].ecyc < q) keep.push_back(expq[i]);
        expq = keep;
        for (int c = q; c < MAXW; c++) exp_busy[c] = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        f = cyc + 1;
        run_model(f, last);

        while (cyc < last) step();
        repeat (4) step();

        n_cmp++;
        if (expq.size() != 0) begin
            n_err += expq.size();
            $display("FAIL missing_events: got %0d events left in queue, want 0, first at edge %0d",
                     expq.size(), expq[0].ecyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_bit_sampler.md
# rx_bit_sampler

Upstream front-end of the UART receiver. Synchronises the asynchronous serial line, generates the oversampling tick from a programmable divider, qualifies start bits at mid-bit, and emits one mid-bit sample per frame bit. Its `strt_bit` output drives `rx_fsm`. Its `bit_valid`/`bit_data` stream feeds the receive shift/parity/stop datapath.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: oversampling ticks per bit. Even, ≥ 8.
- `DIV_W`, default 16: width of the baud divisor.
- `FRAME_BITS`, default 10: bits sampled after the start bit (8 data + parity + stop).

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: raw serial line. Asynchronous; idles high.
- `baud_div`  in  DIV_W: clk cycles per oversample tick. 0 is treated as 1. Sampled continuously; change only while `busy`=0.
- `strt_bit`  out  1: one-clk pulse when a start bit is confirmed.
- `bit_valid`  out  1: one-clk pulse per sampled frame bit.
- `bit_data`  out  1: sampled bit value. Meaningful only while `bit_valid`=1; holds its value otherwise.
- `false_start`  out  1: one-clk pulse when the start bit is rejected as a glitch.
- `framing_err`  out  1: one-clk pulse when the last frame bit (stop) samples 0.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Synchroniser: 2 flops on `rx`. Both reset to 1. `rx_s` is the output of the second flop.
- Tick generator: `baud_cnt` counts 0..max(baud_div,1)-1. `os_tick` is high in the cycle where `baud_cnt` equals the maximum. The generator is cleared to 0 on entry to START.
- FSM states: IDLE, START, BITS, WAIT_HIGH. Reset state is IDLE with `armed`=0.
- IDLE:
  - `armed` sets after any clk with `rx_s`=1.
  - When `armed`=1 and `rx_s`=0: go to START. Clear `tick_cnt` and `baud_cnt`.
  - A line that is low out of reset never starts a frame.
- START:
  - Count `os_tick`. On the (OVERSAMPLE/2)-th tick, sample `rx_s`.
  - Sample 0: pulse `strt_bit`, clear `tick_cnt` and `bit_cnt`, go to BITS.
  - Sample 1: pulse `false_start`, go to IDLE. `armed` stays 1.
- BITS:
  - Every OVERSAMPLE ticks, sample `rx_s`, pulse `bit_valid`, drive `bit_data` with the sample, increment `bit_cnt`.
  - On sample number FRAME_BITS, the stop bit:
    - Value 1: go to IDLE.
    - Value 0: pulse `framing_err` in the same cycle as `bit_valid`, and go to WAIT_HIGH.
- WAIT_HIGH: go to IDLE on the first clk with `rx_s`=1. No pulses are generated while in WAIT_HIGH.
- Edges on `rx` are ignored in START and BITS. Sample position is derived only from the tick count.
- Reset asserted mid-frame, effective immediately:
  - All outputs go to 0.
  - State goes to IDLE and `armed` goes to 0.
  - The synchroniser goes to 1.
  - Any partial frame is discarded.

## Timing
- Reset values: `strt_bit`, `bit_valid`, `bit_data`, `false_start`, `framing_err`, `busy` are all 0.
- All outputs are registered.
- Worked example with `baud_div`=1, OVERSAMPLE=16, and `rx` falling before clk edge N:
  - `rx_s`=0 after edge N+1.
  - START is entered at edge N+2.
  - `strt_bit` is high from edge N+10 to N+11.
  - The first `bit_valid` is at edge N+26. Later ones follow every 16 clks.
- General case: the interval between successive `bit_valid` pulses is OVERSAMPLE·max(baud_div,1) clks.
- `busy` rises at the START entry edge. It falls at the edge of the last `bit_valid`, or at the edge leaving WAIT_HIGH.
- `strt_bit`, `bit_valid`, `false_start` and `framing_err` are never high for more than one clk. `strt_bit` and `bit_valid` are never high together.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined:
  - Each sample is the 2-of-3 majority of `rx_s` at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit.
  - The decision is made on the third of these ticks, so every decision pulse moves one os_tick later. In the worked example, `strt_bit` is at N+11 and the first `bit_valid` at N+27.
- Not defined: a single sample at tick OVERSAMPLE/2, as described above.

## Structure
- Shared package `uart_pkg`:
  - State encoding localparams: IDLE=2'd0, START=2'd1, BITS=2'd2, WAIT_HIGH=2'd3.
  - Default OVERSAMPLE and FRAME_BITS, also used by `rx_fsm`.
- Sub-module `uart_baud_tick`: divisor counter with a synchronous clear. Produces `os_tick`. It is reusable by the transmitter.
- `rx_bit_sampler` contains the synchroniser, the FSM and the optional majority voter.

## Test plan
- Reset with `rx`=1, `baud_div`=1, then send frame 0x55 with even parity and stop=1 → `strt_bit` at N+10. 10 `bit_valid` pulses at N+26+16k. `bit_data` sequence 1,0,1,0,1,0,1,0,0,1. No error pulses.
- Glitch: drive `rx` low for 4 clks, then high → `false_start` pulse at N+10. No `strt_bit`, no `bit_valid`. `busy` returns to 0.
- Stop bit held 0 and the line held low for 50 clks → `framing_err` coincides with the 10th `bit_valid`. `busy` stays high until `rx_s` returns to 1. No new `strt_bit` while the line is low.
- Assert `reset` during the 4th data bit → all outputs 0 at once. The remainder of the frame produces no pulses. The next full frame is received correctly.
- `baud_div`=0 and `baud_div`=3 → `bit_valid` spacing of 16 and 48 clks respectively.
- With `RX_MAJORITY_VOTE_EN`: a one-tick low glitch at the center of a 1 bit → `bit_data`=1, and all pulses delayed by one tick against the non-voting build.
